fetch_prefetch: RTL and testbench

Next-generation fetch unit. Replaces the single-PC, fixed-latency fetch with a request/response instruction-memory interface, a parametrised prefetch buffer and in-flight tracking. Sits between i_mem and decode. Branch/jump target arithmetic moves to execute, which supplies a redirect PC. Decode consumes instructions through a valid/ready handshake.

---
 rtl/fetch_prefetch_pkg.sv | 17 +
 rtl/fetch_prefetch_inst_fifo.sv | 68 ++++++
 rtl/fetch_prefetch.sv | 119 +++++++++++
 tb/tb_fetch_prefetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_pkg.sv
// Shared types and constants for the prefetching fetch unit.
package fetch_prefetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_prefetch_inst_fifo.sv
// Synchronous FIFO of fetched instructions with a single-cycle flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_prefetch_inst_fifo
    import fetch_prefetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] occupancy_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign occupancy_o = wr_ptr_q - rd_ptr_q;
    assign full_o      = (occupancy_o == CNT_W'(DEPTH));
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign head_o      = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push     = push_i & ~full_o & ~flush_i;
    assign do_pop      = pop_i & ~empty_o & ~flush_i;

    // Pointer next-state: flush empties the queue, otherwise advance on push/pop.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone decide which entries are valid.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch unit: issues in-order i_mem requests under a credit limit, buffers
// responses with their PCs, and drops responses made stale by a redirect.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter  logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter  int          DEPTH        = 4,
    localparam int          CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CREDIT_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [CNT_W-1:0]    occupancy;
    logic [CREDIT_W-1:0] credit_used;
    logic                fifo_full;
    logic                fifo_empty;
    fetch_entry_t        head;
    fetch_entry_t        push_entry;
    logic [31:0]         redirect_tgt;
    logic                req_fire;
    logic                drop_rsp;
    logic                push;
    logic                pop;

    // Buffered plus in-flight fetches may never exceed the buffer size, so
    // every response is guaranteed a free slot when it arrives.
    assign credit_used    = {1'b0, occupancy} + {1'b0, outstanding_q};
    assign imem_req_valid = rst & ~redirect & (credit_used < CREDIT_W'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign redirect_tgt = align_pc(redirect_pc);
    assign drop_rsp     = imem_rsp_valid & (discard_q != '0);
    assign push         = imem_rsp_valid & ~drop_rsp & ~redirect;
    assign push_entry   = '{pc: resp_pc_q, inst: imem_rsp_data};

    assign inst_valid = ~fifo_empty & ~redirect;
    assign pop        = inst_valid & inst_ready;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    fetch_prefetch_inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .occupancy_o (occupancy)
    );

    // PC and counter next-state; a redirect retargets both PCs and marks every
    // request still in flight after this cycle for discard.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        discard_d     = discard_q;
        if (redirect) begin
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            discard_d  = outstanding_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)     resp_pc_d  = resp_pc_q + 32'd4;
            if (drop_rsp) discard_d  = discard_q - 1'b1;
        end
    end

    // State registers; reset overrides redirect and responses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Counter sanity: i_mem only answers real requests, and the credit rule bounds everything.
    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (outstanding_q != '0));
    a_occ_bound : assert property (@(posedge clk) disable iff (!rst)
        occupancy <= CNT_W'(DEPTH));
    a_out_bound : assert property (@(posedge clk) disable iff (!rst)
        outstanding_q <= CNT_W'(DEPTH));
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        push |-> !fifo_full);

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a latency-programmable in-order i_mem
// model, an instruction-stream monitor, and a linear sequence of scenarios.
module tb_fetch_prefetch;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_req  = 0;
    int n_pop  = 0;
    int cyc    = 0;
    int lat    = 1;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;
    mreq_t mem_q[$];

    logic [31:0] exp_pc;

    fetch_prefetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction word stored at an address in the memory model.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    // Outputs are observed just after the falling edge.
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_inst(input string tag, input logic [31:0] want_pc);
        int n;
        n = 0;
        while (!inst_valid && n < 20) begin
            next();
            sample();
            n++;
        end
        check({tag, "_valid"}, 32'(inst_valid), 32'd1);
        check({tag, "_pc"}, inst_pc, want_pc);
        check({tag, "_inst"}, inst, word_of(want_pc));
    endtask

    // In-order i_mem: records handshakes, answers each one lat cycles later,
    // and forgets everything in flight when reset is applied.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back('{due: cyc + lat, addr: imem_req_addr});
                n_req++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (!rst) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_of(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Stream monitor: every consumed instruction must continue the PC sequence
    // started by the last reset or redirect, with the matching memory word.
    initial begin
        exp_pc = RV;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_pc = RV;
            end else if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (inst_valid && inst_ready) begin
                check("stream_pc", inst_pc, exp_pc);
                check("stream_inst", inst, word_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_pop++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (compared %0d, mismatched %0d)", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          stall_prev;
        logic [31:0] held_addr;
        int          pops_before;

        rst            = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        lat            = 1;

        // Reset state.
        next();
        next();
        sample();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RV);

        // Release reset: back-to-back requests, first instruction two cycles later.
        next(); rst = 1'b1; sample();                                   // C0
        check("t1_c0_valid", 32'(imem_req_valid), 32'd1);
        check("t1_c0_addr", imem_req_addr, 32'h8000_0000);
        next(); sample();                                               // C1
        check("t1_c1_addr", imem_req_addr, 32'h8000_0004);
        check("t1_c1_inst_valid", 32'(inst_valid), 32'd0);
        next(); sample();                                               // C2
        check("t1_c2_addr", imem_req_addr, 32'h8000_0008);
        check("t1_c2_inst_valid", 32'(inst_valid), 32'd1);
        check("t1_c2_inst_pc", inst_pc, 32'h8000_0000);
        check("t1_c2_inst", inst, word_of(32'h8000_0000));

        // Back-pressure: four credits, then stall until decode takes one.
        next(); sample();                                               // C3
        check("t2_c3_addr", imem_req_addr, 32'h8000_000C);
        next(); sample();                                               // C4
        check("t2_c4_valid", 32'(imem_req_valid), 32'd0);
        next(); inst_ready = 1'b1; sample();                            // C5
        check("t2_c5_valid", 32'(imem_req_valid), 32'd0);
        check("t2_nreq4", 32'(n_req), 32'd4);
        check("t2_c5_head", inst_pc, 32'h8000_0000);
        next(); inst_ready = 1'b0; sample();                            // C6
        check("t2_c6_valid", 32'(imem_req_valid), 32'd1);
        check("t2_c6_addr", imem_req_addr, 32'h8000_0010);
        check("t2_c6_head", inst_pc, 32'h8000_0004);
        next(); sample();                                               // C7
        check("t2_c7_valid", 32'(imem_req_valid), 32'd0);
        next(); sample();                                               // C8
        check("t2_c8_valid", 32'(imem_req_valid), 32'd0);
        check("t2_nreq5", 32'(n_req), 32'd5);

        // Drain with requests stalled, then redirect with two in flight at latency 3.
        next(); inst_ready = 1'b1; imem_req_ready = 1'b0; sample();     // C9
        repeat (3) begin next(); sample(); end                          // C10..C12
        next(); lat = 3; imem_req_ready = 1'b1; sample();               // C13
        check("t3_c13_empty", 32'(inst_valid), 32'd0);
        check("t3_c13_addr", imem_req_addr, 32'h8000_0014);
        next(); sample();                                               // C14
        check("t3_c14_addr", imem_req_addr, 32'h8000_0018);
        next(); redirect = 1'b1; redirect_pc = 32'h8000_0100; sample(); // C15
        check("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
        next(); redirect = 1'b0; sample();                              // C16
        check("t3_new_valid", 32'(imem_req_valid), 32'd1);
        check("t3_new_addr", imem_req_addr, 32'h8000_0100);
        next(); sample();                                               // C17
        next(); sample();                                               // C18
        check("t3_c18_inst_valid", 32'(inst_valid), 32'd0);
        next(); sample();                                               // C19
        check("t3_c19_inst_valid", 32'(inst_valid), 32'd0);
        next(); sample();                                               // C20
        check("t3_c20_inst_valid", 32'(inst_valid), 32'd1);
        check("t3_c20_inst_pc", inst_pc, 32'h8000_0100);

        // Redirect coinciding with a live response and a ready decode.
        next(); redirect = 1'b1; redirect_pc = 32'h8000_0200; sample(); // C21
        check("t4_redir_inst_valid", 32'(inst_valid), 32'd0);
        check("t4_redir_req_valid", 32'(imem_req_valid), 32'd0);
        next(); redirect = 1'b0; sample();                              // C22
        check("t4_new_addr", imem_req_addr, 32'h8000_0200);
        check("t4_flushed", 32'(inst_valid), 32'd0);
        wait_inst("t4_first", 32'h8000_0200);

        // Random request and decode stalls: address must hold while stalled.
        lat         = 2;
        stall_prev  = 1'b0;
        held_addr   = '0;
        pops_before = n_pop;
        for (int i = 0; i < 60; i++) begin
            next();
            imem_req_ready = 1'($urandom_range(0, 1));
            inst_ready     = 1'($urandom_range(0, 1));
            sample();
            if (stall_prev) begin
                check("t5_hold_valid", 32'(imem_req_valid), 32'd1);
                check("t5_hold_addr", imem_req_addr, held_addr);
            end
            stall_prev = imem_req_valid && !imem_req_ready;
            held_addr  = imem_req_addr;
        end
        next(); imem_req_ready = 1'b0; inst_ready = 1'b1;
        repeat (12) next();
        sample();
        check("t5_drained", 32'(inst_valid), 32'd0);
        check("t5_progress", 32'(n_pop > pops_before), 32'd1);

        // Misaligned redirect target is word aligned.
        next(); imem_req_ready = 1'b1; lat = 1; redirect = 1'b1; redirect_pc = 32'h8000_0102; sample();
        check("t6_redir_req_valid", 32'(imem_req_valid), 32'd0);
        next(); redirect = 1'b0; sample();
        check("t6_aligned_addr", imem_req_addr, 32'h8000_0100);
        wait_inst("t6_first", 32'h8000_0100);

        // Reset wins over a simultaneous redirect, mid-stream.
        next(); rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h1234_5678; sample();
        check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        next(); sample();
        check("t6_rst_addr", imem_req_addr, RV);
        check("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
        next(); rst = 1'b1; redirect = 1'b0; sample();
        check("t6_post_rst_valid", 32'(imem_req_valid), 32'd1);
        check("t6_post_rst_addr", imem_req_addr, RV);
        wait_inst("t6_post_rst", RV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
